// File: rtl/issue_wakeup_int_if.sv
// issue_wakeup_int_if: issue-queue <-> integer execution completion tracker.
//   issue_wakeup_int_pkg : micro_op_t / fu_code_t payload types.
//   uop_issued           : per-pipe issued uops (queue -> tracker).
//   ctb_prf_int_index    : per-lane wakeup tags (tracker -> queue).
//   ctb_valid            : per-lane wakeup valids (tracker -> queue).
//   ex_busy              : per-pipe issue block (tracker -> queue).
//   issue_err            : sticky protocol-violation flag (tracker -> queue).
`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

package issue_wakeup_int_pkg;
   localparam int unsigned PRF_IDX_W = `PRF_INT_INDEX_SIZE;

   typedef struct packed {
      logic fu_alu;
      logic fu_br;
      logic fu_mul;
      logic fu_div;
   } fu_code_t;

   typedef struct packed {
      logic                 valid;
      fu_code_t             fu_code;
      logic                 rd_valid;
      logic [PRF_IDX_W-1:0] rd_prf_int_index;
   } micro_op_t;
endpackage

interface issue_wakeup_int_if
   import issue_wakeup_int_pkg::*;
#(
   parameter int unsigned ISSUE_WIDTH = `ISSUE_WIDTH_INT,
   parameter int unsigned PRF_INDEX_W = `PRF_INT_INDEX_SIZE
);
   micro_op_t [ISSUE_WIDTH-1:0]               uop_issued;
   logic [ISSUE_WIDTH-1:0][PRF_INDEX_W-1:0]   ctb_prf_int_index;
   logic [ISSUE_WIDTH-1:0]                    ctb_valid;
   logic [ISSUE_WIDTH-1:0]                    ex_busy;
   logic                                      issue_err;

   modport master (output uop_issued,
                   input  ctb_prf_int_index, ctb_valid, ex_busy, issue_err);
   modport slave  (input  uop_issued,
                   output ctb_prf_int_index, ctb_valid, ex_busy, issue_err);
endinterface

// File: rtl/issue_wakeup_int.sv
// issue_wakeup_int: integer execution completion tracker. Models ALU/BR (1 cycle),
// pipelined MUL (pipe 1) and iterative DIV (pipe 2) latencies, drives the common
// tag bus and back-pressures the issue queue so CTB lanes never collide.
//   clock, reset : clock, asynchronous active-high reset
//   flush        : synchronous kill of all in-flight work
//   bus (slave)  : uop_issued in; ctb_prf_int_index, ctb_valid, ex_busy, issue_err out
// Build option: define IQ_WAKEUP_CHECK_EN to enable illegal-fu / issue-while-busy
// detection on issue_err; otherwise issue_err is 0 and any valid uop is routed
// DIV > MUL > ALU within the paths its pipe owns.
`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module issue_wakeup_int
   import issue_wakeup_int_pkg::*;
#(
   parameter int unsigned ISSUE_WIDTH = `ISSUE_WIDTH_INT,
   parameter int unsigned PRF_INDEX_W = `PRF_INT_INDEX_SIZE,
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned DIV_LATENCY = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   issue_wakeup_int_if.slave bus
);
   localparam int unsigned MUL_STAGES = MUL_LATENCY - 1;
   localparam int unsigned CNT_W      = $clog2(DIV_LATENCY) + 1;

   typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

   logic [MUL_STAGES-1:0]                   mul_v_q, mul_v_d;
   logic [MUL_STAGES-1:0]                   mul_rd_q, mul_rd_d;
   logic [MUL_STAGES-1:0][PRF_INDEX_W-1:0]  mul_tag_q, mul_tag_d;
   div_state_e                              div_state_q, div_state_d;
   logic [CNT_W-1:0]                        div_cnt_q, div_cnt_d;
   logic                                    div_rd_q, div_rd_d;
   logic [PRF_INDEX_W-1:0]                  div_tag_q, div_tag_d;
   logic [ISSUE_WIDTH-1:0]                  ctb_valid_q, ctb_valid_d;
   logic [ISSUE_WIDTH-1:0][PRF_INDEX_W-1:0] ctb_idx_q, ctb_idx_d;
   logic                                    issue_err_q, issue_err_d;

   logic [ISSUE_WIDTH-1:0] busy_c, legal_c, accept_c, to_mul_c, to_div_c;
   logic                   err_c;
   logic                   div_done_c;
   logic                   unused_uop;

   // Not every uop field matters to every pipe.
   assign unused_uop = ^bus.uop_issued;

   // Busy depends on registers only: last MUL stage about to own lane 1, DIV FSM owns lane 2.
   always_comb begin
      busy_c    = '0;
      busy_c[1] = mul_v_q[MUL_STAGES-1];
      busy_c[2] = (div_state_q == DIV_BUSY);
   end

   // Per-pipe acceptance and routing.
   always_comb begin
      legal_c  = '0;
      accept_c = '0;
      to_mul_c = '0;
      to_div_c = '0;
      err_c    = 1'b0;
      for (int p = 0; p < int'(ISSUE_WIDTH); p++) begin
         to_mul_c[p] = (p == 1) && bus.uop_issued[p].fu_code.fu_mul;
         to_div_c[p] = (p == 2) && bus.uop_issued[p].fu_code.fu_div;
`ifdef IQ_WAKEUP_CHECK_EN
         if (p == 1)
            legal_c[p] = bus.uop_issued[p].fu_code.fu_alu | bus.uop_issued[p].fu_code.fu_mul;
         else if (p == 2)
            legal_c[p] = bus.uop_issued[p].fu_code.fu_alu | bus.uop_issued[p].fu_code.fu_div;
         else
            legal_c[p] = bus.uop_issued[p].fu_code.fu_alu | bus.uop_issued[p].fu_code.fu_br;
         err_c = err_c | (bus.uop_issued[p].valid & ~flush & (busy_c[p] | ~legal_c[p]));
`else
         legal_c[p] = 1'b1;
`endif
         accept_c[p] = bus.uop_issued[p].valid & ~flush & ~busy_c[p] & legal_c[p];
      end
   end

   // Next state for MUL pipe, DIV FSM, CTB lanes and error flag.
   always_comb begin
      mul_v_d     = '0;
      mul_rd_d    = '0;
      mul_tag_d   = '0;
      div_state_d = div_state_q;
      div_cnt_d   = div_cnt_q;
      div_rd_d    = div_rd_q;
      div_tag_d   = div_tag_q;
      div_done_c  = 1'b0;
      ctb_valid_d = '0;
      ctb_idx_d   = '0;

      mul_v_d[0]   = accept_c[1] & to_mul_c[1];
      mul_rd_d[0]  = bus.uop_issued[1].rd_valid;
      mul_tag_d[0] = PRF_INDEX_W'(bus.uop_issued[1].rd_prf_int_index);
      for (int s = 1; s < int'(MUL_STAGES); s++) begin
         mul_v_d[s]   = mul_v_q[s-1];
         mul_rd_d[s]  = mul_rd_q[s-1];
         mul_tag_d[s] = mul_tag_q[s-1];
      end

      case (div_state_q)
         DIV_IDLE: begin
            if (accept_c[2] && to_div_c[2]) begin
               div_state_d = DIV_BUSY;
               div_cnt_d   = CNT_W'(DIV_LATENCY - 1);
               div_rd_d    = bus.uop_issued[2].rd_valid;
               div_tag_d   = PRF_INDEX_W'(bus.uop_issued[2].rd_prf_int_index);
            end
         end
         DIV_BUSY: begin
            div_cnt_d = div_cnt_q - CNT_W'(1);
            if (div_cnt_q == CNT_W'(1)) begin
               div_state_d = DIV_IDLE;
               div_done_c  = 1'b1;
            end
         end
         default: div_state_d = DIV_IDLE;
      endcase

      // Single-cycle results; long-latency results own their lane while busy blocks issue.
      for (int p = 0; p < int'(ISSUE_WIDTH); p++) begin
         if (accept_c[p] && !to_mul_c[p] && !to_div_c[p]) begin
            ctb_valid_d[p] = bus.uop_issued[p].rd_valid;
            ctb_idx_d[p]   = PRF_INDEX_W'(bus.uop_issued[p].rd_prf_int_index);
         end
      end
      if (mul_v_q[MUL_STAGES-1]) begin
         ctb_valid_d[1] = mul_rd_q[MUL_STAGES-1];
         ctb_idx_d[1]   = mul_tag_q[MUL_STAGES-1];
      end
      if (div_done_c) begin
         ctb_valid_d[2] = div_rd_q;
         ctb_idx_d[2]   = div_tag_q;
      end

      if (flush) begin
         mul_v_d     = '0;
         div_state_d = DIV_IDLE;
         div_cnt_d   = '0;
         ctb_valid_d = '0;
         ctb_idx_d   = '0;
      end

`ifdef IQ_WAKEUP_CHECK_EN
      issue_err_d = issue_err_q | err_c;
`else
      issue_err_d = 1'b0;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mul_v_q     <= '0;
         mul_rd_q    <= '0;
         mul_tag_q   <= '0;
         div_state_q <= DIV_IDLE;
         div_cnt_q   <= '0;
         div_rd_q    <= 1'b0;
         div_tag_q   <= '0;
         ctb_valid_q <= '0;
         ctb_idx_q   <= '0;
         issue_err_q <= 1'b0;
      end else begin
         mul_v_q     <= mul_v_d;
         mul_rd_q    <= mul_rd_d;
         mul_tag_q   <= mul_tag_d;
         div_state_q <= div_state_d;
         div_cnt_q   <= div_cnt_d;
         div_rd_q    <= div_rd_d;
         div_tag_q   <= div_tag_d;
         ctb_valid_q <= ctb_valid_d;
         ctb_idx_q   <= ctb_idx_d;
         issue_err_q <= issue_err_d;
      end
   end

   assign bus.ctb_valid         = ctb_valid_q;
   assign bus.ctb_prf_int_index = ctb_idx_q;
   assign bus.ex_busy           = busy_c;
   assign bus.issue_err         = issue_err_q;
endmodule
